// File: rtl/wr_pkt_scheduler.sv
// Packet-granular SP/WRR scheduler for the 16-port SRAM write path.
// Optional watchdog abort is compiled in with `define ARB_WDOG_EN.
module wr_pkt_scheduler #(
   parameter int NUM_PORTS   = 16,
   parameter int PRIO_W      = 3,
   parameter int SEL_W       = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        mode_i,
   input  logic [NUM_PORTS-1:0]        req_i,
   input  logic [NUM_PORTS-1:0]        eop_i,
   input  logic [NUM_PORTS*PRIO_W-1:0] prio_i,
   output logic [NUM_PORTS-1:0]        grant_o,
   output logic [SEL_W-1:0]            sel_o,
   output logic                        busy_o,
   output logic                        timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic                 last_mode_q, last_mode_d;
   logic [3:0]           credit_q [NUM_PORTS];
   logic [3:0]           credit_d [NUM_PORTS];

   logic [3:0]           reload_val [NUM_PORTS];
   logic [3:0]           eff_credit [NUM_PORTS];
   logic [3:0]           base_credit [NUM_PORTS];
   logic [SEL_W-1:0]     eff_ptr;
   logic                 mode_chg;
   logic                 wrr_found, any_found, sp_found;
   logic [SEL_W-1:0]     wrr_win, any_win, sp_win, winner;
   logic [PRIO_W-1:0]    sp_best;
   logic                 wdog_expire;

`ifdef ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   assign wdog_expire = (state_q == S_XFER) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
   assign wdog_expire = 1'b0;
`endif

   // A mode change behaves as if credits were just reloaded and ptr parked at the top.
   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      mode_chg  = (mode_i != last_mode_q);
      eff_ptr   = mode_chg ? '1 : ptr_q;
      wrr_found = 1'b0;
      any_found = 1'b0;
      wrr_win   = '0;
      any_win   = '0;
      sp_found  = 1'b0;
      sp_win    = '0;
      sp_best   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         reload_val[i] = 4'(prio_i[i*PRIO_W +: PRIO_W]) + 4'd1;
         eff_credit[i] = mode_chg ? reload_val[i] : credit_q[i];
      end
      for (int k = 1; k <= NUM_PORTS; k++) begin
         int idx;
         idx = (int'(eff_ptr) + k) % NUM_PORTS;
         if (req_i[idx] && !any_found) begin
            any_found = 1'b1;
            any_win   = SEL_W'(idx);
         end
         if (req_i[idx] && (eff_credit[idx] != 4'd0) && !wrr_found) begin
            wrr_found = 1'b1;
            wrr_win   = SEL_W'(idx);
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req_i[i] && (!sp_found || (prio_i[i*PRIO_W +: PRIO_W] > sp_best))) begin
            sp_found = 1'b1;
            sp_win   = SEL_W'(i);
            sp_best  = prio_i[i*PRIO_W +: PRIO_W];
         end
      end
      // With no credited requester all credits reload, so the first requester wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
         base_credit[i] = wrr_found ? eff_credit[i] : reload_val[i];
      end
      winner = mode_i ? (wrr_found ? wrr_win : any_win) : sp_win;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      last_mode_d = last_mode_q;
      credit_d    = credit_q;
`ifdef ARB_WDOG_EN
      wdog_d      = wdog_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            last_mode_d = mode_i;
            if (mode_chg) begin
               credit_d = reload_val;
               ptr_d    = '1;
            end
            busy_d = 1'b0;
            if (|req_i) begin
               state_d = S_XFER;
               grant_d = NUM_PORTS'(1) << winner;
               sel_d   = winner;
               busy_d  = 1'b1;
`ifdef ARB_WDOG_EN
               wdog_d  = '0;
`endif
               if (mode_i) begin
                  credit_d         = base_credit;
                  credit_d[winner] = base_credit[winner] - 4'd1;
                  ptr_d            = winner;
               end
            end
         end
         S_XFER: begin
`ifdef ARB_WDOG_EN
            wdog_d = wdog_q + 1'b1;
`endif
            if (eop_i[sel_q] || wdog_expire) begin
               state_d   = S_GAP;
               grant_d   = '0;
               sel_d     = '1;
               timeout_d = wdog_expire && !eop_i[sel_q];
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   // NOTE: the credit array is reset because WRR arbitration reads it before any reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         sel_q       <= '1;
         ptr_q       <= '1;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         last_mode_q <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) credit_q[i] <= 4'd0;
`ifdef ARB_WDOG_EN
         wdog_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         last_mode_q <= last_mode_d;
         credit_q    <= credit_d;
`ifdef ARB_WDOG_EN
         wdog_q      <= wdog_d;
`endif
      end
   end

   assign grant_o   = grant_q;
   assign sel_o     = sel_q;
   assign busy_o    = busy_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wr_pkt_scheduler.sv
// Directed bench for wr_pkt_scheduler; the watchdog scenario uses WDOG_CYCLES=8
// when ARB_WDOG_EN is defined, otherwise a 100-cycle hold is checked.
module tb_wr_pkt_scheduler;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [15:0] req;
   logic [15:0] eop;
   logic [47:0] prio;
   logic [15:0] grant;
   logic [3:0]  sel;
   logic        busy;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;

`ifdef ARB_WDOG_EN
   localparam int WDOG = 8;
`else
   localparam int WDOG = 1024;
`endif

   wr_pkt_scheduler #(.NUM_PORTS(16), .PRIO_W(3), .SEL_W(4), .WDOG_CYCLES(WDOG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_i    (mode),
      .req_i     (req),
      .eop_i     (eop),
      .prio_i    (prio),
      .grant_o   (grant),
      .sel_o     (sel),
      .busy_o    (busy),
      .timeout_o (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b0; eop = '0; prio = '0;
      for (int i = 0; i < 4; i++) begin
         req = 16'($urandom);
         step();
      end
      n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL reset_grant: got %h want 0000", grant); end
      n_cmp++; if (sel !== 4'hf) begin n_err++; $display("FAIL reset_sel: got %h want f", sel); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      rst_n = 1'b1; req = 16'h0001;
      step();
      n_cmp++; if (grant !== 16'h0001) begin n_err++; $display("FAIL first_grant: got %h want 0001", grant); end
      n_cmp++; if (sel !== 4'h0) begin n_err++; $display("FAIL first_sel: got %h want 0", sel); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b want 1", busy); end
      eop = 16'h0001; req = '0;
      step();
      n_cmp++; if (grant !== 16'h0 || sel !== 4'hf || busy !== 1'b1) begin
         n_err++; $display("FAIL gap_state: got grant=%h sel=%h busy=%b want 0000 f 1", grant, sel, busy); end
      eop = '0;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_gap: got %b want 0", busy); end
   endtask

   task automatic test_sp();
      mode = 1'b0; prio = '0;
      prio[2*3 +: 3] = 3'd3; prio[10*3 +: 3] = 3'd5; prio[11*3 +: 3] = 3'd5;
      req = 16'h0C04; eop = '0;
      step();
      n_cmp++; if (sel !== 4'd10 || grant !== 16'h0400) begin
         n_err++; $display("FAIL sp_win: got sel=%0d grant=%h want 10 0400", sel, grant); end
      eop = 16'h0400;
      step();
      n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL sp_gap1: got %h want 0000", grant); end
      eop = '0;
      step();
      n_cmp++; if (grant !== 16'h0 || busy !== 1'b0) begin
         n_err++; $display("FAIL sp_gap2: got grant=%h busy=%b want 0000 0", grant, busy); end
      step();
      n_cmp++; if (sel !== 4'd10 || busy !== 1'b1) begin
         n_err++; $display("FAIL sp_regrant: got sel=%0d busy=%b want 10 1", sel, busy); end
      eop = 16'h0400; req = '0;
      step();
      eop = '0;
      step();
   endtask

   task automatic test_wrr_weights();
      int exp_seq[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
      mode = 1'b1; prio = '0;
      prio[0 +: 3] = 3'd1; prio[3 +: 3] = 3'd0;
      req = 16'h0003; eop = 16'hffff;
      step();
      for (int k = 0; k < 9; k++) begin
         n_cmp++; if (sel !== 4'(exp_seq[k]) || grant !== (16'h1 << exp_seq[k])) begin
            n_err++; $display("FAIL wrr_seq[%0d]: got sel=%0d grant=%h want %0d", k, sel, grant, exp_seq[k]); end
         step();
         step();
         n_cmp++; if (grant !== 16'h0) begin
            n_err++; $display("FAIL wrr_gap[%0d]: got %h want 0000", k, grant); end
         if (k == 8) req = '0;
         step();
      end
      step();
   endtask

   task automatic test_wrap();
      mode = 1'b1; prio = '0;
      prio[0 +: 3] = 3'd1; prio[15*3 +: 3] = 3'd2;
      req = 16'h8000; eop = 16'hffff;
      step();
      n_cmp++; if (sel !== 4'd15) begin n_err++; $display("FAIL wrap_first: got %0d want 15", sel); end
      req = 16'h8001;
      repeat (3) step();
      n_cmp++; if (sel !== 4'd0) begin n_err++; $display("FAIL wrap_port0: got %0d want 0", sel); end
      repeat (3) step();
      n_cmp++; if (sel !== 4'd15) begin n_err++; $display("FAIL wrap_back15: got %0d want 15", sel); end
      req = '0;
      repeat (3) step();
   endtask

   task automatic test_ignored_events();
      mode = 1'b0; prio = '0; req = 16'h0008; eop = '0;
      step();
      n_cmp++; if (grant !== 16'h0008) begin n_err++; $display("FAIL ign_grant: got %h want 0008", grant); end
      req = '0; eop = 16'h0020;
      step();
      n_cmp++; if (grant !== 16'h0008) begin n_err++; $display("FAIL ign_eop5: got %h want 0008", grant); end
      eop = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (grant !== 16'h0008) begin n_err++; $display("FAIL ign_hold[%0d]: got %h want 0008", i, grant); end
      end
      eop = 16'h0008;
      step();
      n_cmp++; if (grant !== 16'h0 || sel !== 4'hf) begin
         n_err++; $display("FAIL ign_release: got grant=%h sel=%h want 0000 f", grant, sel); end
      eop = '0;
      repeat (2) step();
   endtask

   task automatic test_watchdog();
      mode = 1'b0; prio = '0; req = 16'h0004; eop = '0;
      step();
      n_cmp++; if (grant !== 16'h0004) begin n_err++; $display("FAIL wd_grant: got %h want 0004", grant); end
      req = '0;
`ifdef ARB_WDOG_EN
      for (int c = 1; c < 8; c++) begin
         step();
         n_cmp++; if (grant !== 16'h0004 || timeout !== 1'b0) begin
            n_err++; $display("FAIL wd_hold[%0d]: got grant=%h timeout=%b want 0004 0", c, grant, timeout); end
      end
      step();
      n_cmp++; if (grant !== 16'h0 || timeout !== 1'b1) begin
         n_err++; $display("FAIL wd_abort: got grant=%h timeout=%b want 0000 1", grant, timeout); end
      step();
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_pulse: got %b want 0", timeout); end
      step();
`else
      begin
         int bad = 0;
         for (int c = 0; c < 100; c++) begin
            step();
            if (grant !== 16'h0004 || timeout !== 1'b0) bad++;
         end
         n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_100: got %0d bad cycles want 0", bad); end
      end
      eop = 16'h0004;
      step();
      n_cmp++; if (grant !== 16'h0 || timeout !== 1'b0) begin
         n_err++; $display("FAIL hold_release: got grant=%h timeout=%b want 0000 0", grant, timeout); end
      eop = '0;
      repeat (2) step();
`endif
   endtask

   task automatic test_async_reset();
      mode = 1'b0; prio = '0; req = 16'h0010; eop = '0;
      step();
      n_cmp++; if (grant !== 16'h0010) begin n_err++; $display("FAIL ar_grant: got %h want 0010", grant); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (grant !== 16'h0 || sel !== 4'hf || busy !== 1'b0) begin
         n_err++; $display("FAIL ar_drop: got grant=%h sel=%h busy=%b want 0000 f 0", grant, sel, busy); end
      step();
      rst_n = 1'b1; req = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_sp();
      test_wrr_weights();
      test_wrap();
      test_ignored_events();
      test_watchdog();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
